// File: rtl/i2c_stat_irq_pkg.sv
// Shared definitions for the I2C status/interrupt block: status field offsets,
// event bit indices and the bench sampling delay.
package i2c_stat_irq_pkg;

  localparam int NEVT_DEF = 3;

  localparam int EVT_LSB  = 0;
  localparam int OVR_LSB  = NEVT_DEF;
  localparam int LIVE_LSB = 2 * NEVT_DEF;

  // Event indices inside the evt/ovr/ien fields.
  localparam int EVT_TD = 0;
  localparam int EVT_NA = 1;
  localparam int EVT_AF = 2;

  // Sampling delay after the active clock edge.
  localparam int TQ = 1;

  function automatic int ovr_lsb(input int nevt);
    return nevt;
  endfunction

  function automatic int live_lsb(input int nevt);
    return 2 * nevt;
  endfunction

endpackage

// File: rtl/i2c_sticky_bit.sv
// One sticky event slice: event flag, overrun flag and the previous-input
// register used for rising-edge detection.
module i2c_sticky_bit #(
  parameter bit EDGE = 1'b0
) (
  input  logic clk,
  input  logic rst_an,
  input  logic set_req,
  input  logic clr_req,
  input  logic ovr_clr,
  output logic evt,
  output logic ovr,
  output logic evt_nxt
);

  logic prev;
  logic set_eff;
  logic ovr_nxt;

  // A set always beats a clear; overrun needs a set landing on a still-pending event.
  always_comb begin
    set_eff = EDGE ? (set_req & ~prev) : set_req;
    evt_nxt = set_eff | (evt & ~clr_req);
    ovr_nxt = (set_eff & evt & ~clr_req) | (ovr & ~ovr_clr);
  end

  always_ff @(posedge clk) begin
    if (!rst_an) begin
      prev <= 1'b0;
      evt  <= 1'b0;
      ovr  <= 1'b0;
    end else begin
      prev <= set_req;
      evt  <= evt_nxt;
      ovr  <= ovr_nxt;
    end
  end

endmodule

// File: rtl/i2c_stat_irq.sv
// I2C status and interrupt block: sticky event/overrun bits, interrupt-enable
// register, registered irq and the {live, ovr, evt} status word.
module i2c_stat_irq
  import i2c_stat_irq_pkg::*;
#(
  parameter int              NEVT      = 3,
  parameter int              NLIVE     = 7,
  parameter logic [NEVT-1:0] EDGE_MASK = '0,
  localparam int             LW        = (NLIVE > 0) ? NLIVE : 1
) (
  input  logic                    clk,
  input  logic                    rst_an,
  input  logic                    wr_sts,
  input  logic                    wr_ien,
  input  logic [2*NEVT-1:0]       di,
  input  logic [NEVT-1:0]         set_evt,
  input  logic [NEVT-1:0]         clr_evt,
  input  logic [LW-1:0]           live,
  output logic [2*NEVT+NLIVE-1:0] status,
  output logic [NEVT-1:0]         ien,
  output logic                    irq
);

  localparam int OVR_OFS  = ovr_lsb(NEVT);
  localparam int LIVE_OFS = live_lsb(NEVT);

  logic [NEVT-1:0] evt;
  logic [NEVT-1:0] ovr;
  logic [NEVT-1:0] evt_nxt;
  logic [NEVT-1:0] ien_nxt;

  for (genvar i = 0; i < NEVT; i++) begin : g_bit
    i2c_sticky_bit #(
      .EDGE(EDGE_MASK[i])
    ) u_bit (
      .clk    (clk),
      .rst_an (rst_an),
      .set_req(set_evt[i]),
      .clr_req((wr_sts & di[i]) | clr_evt[i]),
      .ovr_clr(wr_sts & di[NEVT+i]),
      .evt    (evt[i]),
      .ovr    (ovr[i]),
      .evt_nxt(evt_nxt[i])
    );
  end

  always_comb begin
    ien_nxt = wr_ien ? di[NEVT-1:0] : ien;
  end

  // irq is built from the next-state values so it rises together with evt/ien.
  always_ff @(posedge clk) begin
    if (!rst_an) begin
      ien <= '0;
      irq <= 1'b0;
    end else begin
      ien <= ien_nxt;
      irq <= |(evt_nxt & ien_nxt);
    end
  end

  assign status[EVT_LSB +: NEVT] = evt;
  assign status[OVR_OFS +: NEVT] = ovr;

  if (NLIVE > 0) begin : g_live
    assign status[LIVE_OFS +: LW] = live;
  end

endmodule
